fp_counter_bank: RTL

- Parametrised successor to the single-channel fixed-point step counter used alongside the TinyQV peripheral harness.
- Holds CHANNELS independent accumulators, each WIDTH bits wide. Each accumulator adds a signed, shifted step.
- Each channel has its own mode (wrap, saturate, one-shot), its own limit, sticky flags and a limit-crossing event pulse.
- Sits next to the harness as a bench or peripheral helper; steps arrive on a shared time-multiplexed port.

---
 rtl/fp_counter_pkg.sv | 13 +
 rtl/fp_counter_lane.sv | 106 ++++++++++
 rtl/fp_counter_bank.sv | 84 ++++++++
 3 files changed

// File: rtl/fp_counter_pkg.sv
// rtl/fp_counter_pkg.sv - shared mode encodings and flag positions for the counter bank
package fp_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP    = 2'd0;
  localparam mode_t MODE_SAT     = 2'd1;
  localparam mode_t MODE_ONESHOT = 2'd2;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_DONE = 1;

endpackage

// File: rtl/fp_counter_lane.sv
// rtl/fp_counter_lane.sv - one accumulator channel: state, signed step add, clamp and limit event
module fp_counter_lane
  import fp_counter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STEP_W     = 8,
  parameter int STEP_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_en,
  input  logic signed [STEP_W-1:0] step,
  input  logic                     clr,
  input  logic                     cfg_we,
  input  mode_t                    cfg_mode,
  input  logic [WIDTH-1:0]         cfg_limit,
  output logic [WIDTH-1:0]         value,
  output logic                     ovf,
  output logic                     done,
  output logic                     evt
);

  // Two guard bits above the shifted range keep the sum free of wraparound.
  localparam int SUM_W = WIDTH + STEP_SHIFT + 2;

  mode_t                    mode;
  logic [WIDTH-1:0]         limit;
  logic signed [SUM_W-1:0]  step_ext;
  logic signed [SUM_W-1:0]  sum;
  logic                     under;
  logic                     over;
  logic [WIDTH-1:0]         wrap_val;
  logic [WIDTH-1:0]         sat_val;
  logic [WIDTH-1:0]         next_value;
  logic                     next_ovf;
  logic                     next_done;
  logic                     crossing;

  assign step_ext = SUM_W'(step) <<< STEP_SHIFT;
  assign sum      = $signed({{(SUM_W-WIDTH){1'b0}}, value}) + step_ext;
  assign under    = sum[SUM_W-1];
  assign over     = !under && (|sum[SUM_W-2:WIDTH]);
  assign wrap_val = sum[WIDTH-1:0];
  assign sat_val  = under ? '0 : (over ? '1 : sum[WIDTH-1:0]);

  always_comb begin
    next_value = value;
    next_ovf   = ovf;
    next_done  = done;
    if (step_en) begin
      case (mode)
        MODE_SAT: begin
          next_value = sat_val;
          next_ovf   = ovf | under | over;
        end
        MODE_ONESHOT: begin
          // Once done, the channel ignores steps until cleared or reconfigured.
          if (!done) begin
            next_ovf = ovf | under | over;
            if (sat_val >= limit) begin
              next_value = limit;
              next_done  = 1'b1;
            end else begin
              next_value = sat_val;
            end
          end
        end
        default: begin
          next_value = wrap_val;
          next_ovf   = ovf | under | over;
        end
      endcase
    end
  end

  assign crossing = step_en && (value < limit) && (next_value >= limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      evt   <= 1'b0;
      mode  <= MODE_WRAP;
      limit <= '1;
    end else begin
      evt <= crossing && !clr;
      if (clr) begin
        value <= '0;
        ovf   <= 1'b0;
        done  <= 1'b0;
      end else begin
        value <= next_value;
        ovf   <= next_ovf;
        done  <= next_done;
      end
      // A config write re-arms the channel; a same-cycle step already used the old settings.
      if (cfg_we) begin
        mode  <= cfg_mode;
        limit <= cfg_limit;
        done  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_counter_bank.sv
// rtl/fp_counter_bank.sv - bank of fixed-point step counters with shared step port and readout
module fp_counter_bank
  import fp_counter_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int STEP_W     = 8,
  parameter int STEP_SHIFT = 0,
  parameter int CH_W       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_en,
  input  logic [CH_W-1:0]           step_ch,
  input  logic signed [STEP_W-1:0]  step,
  input  logic                      clr,
  input  logic [CH_W-1:0]           clr_ch,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  mode_t                     cfg_mode,
  input  logic [WIDTH-1:0]          cfg_limit,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [WIDTH-1:0]          rd_value,
  output logic [1:0]                rd_flags,
  output logic [CHANNELS*WIDTH-1:0] value_all,
  output logic [CHANNELS-1:0]       evt
);

  logic [WIDTH-1:0] lane_value [CHANNELS];
  logic             lane_ovf   [CHANNELS];
  logic             lane_done  [CHANNELS];
  logic [WIDTH-1:0] rd_value_nx;
  logic [1:0]       rd_flags_nx;

  // Indices with no matching lane simply select nothing.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [CH_W-1:0] IDX = CH_W'(c);

    fp_counter_lane #(
      .WIDTH      (WIDTH),
      .STEP_W     (STEP_W),
      .STEP_SHIFT (STEP_SHIFT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .step_en   (step_en && (step_ch == IDX)),
      .step      (step),
      .clr       (clr && (clr_ch == IDX)),
      .cfg_we    (cfg_we && (cfg_ch == IDX)),
      .cfg_mode  (cfg_mode),
      .cfg_limit (cfg_limit),
      .value     (lane_value[c]),
      .ovf       (lane_ovf[c]),
      .done      (lane_done[c]),
      .evt       (evt[c])
    );

    assign value_all[c*WIDTH +: WIDTH] = lane_value[c];
  end

  always_comb begin
    rd_value_nx = '0;
    rd_flags_nx = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rd_value_nx            = lane_value[c];
        rd_flags_nx[FLAG_OVF]  = lane_ovf[c];
        rd_flags_nx[FLAG_DONE] = lane_done[c];
      end
    end
  end

  // Sampled from pre-edge lane state, so same-edge updates show one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_value <= '0;
      rd_flags <= '0;
    end else begin
      rd_value <= rd_value_nx;
      rd_flags <= rd_flags_nx;
    end
  end

endmodule
